pll_rst_seq: RTL



---
 rtl/pll_rst_seq_pkg.sv | 20 ++
 rtl/pll_rst_seq_sync2.sv | 21 ++
 rtl/pll_rst_seq.sv | 104 ++++++++++
 3 files changed

// File: rtl/pll_rst_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and output widths.
package pll_rst_seq_pkg;

  localparam int STATE_W = 3;
  localparam int LOSS_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_PERIPH    = 3'd3,
    ST_RUN       = 3'd4,
    ST_SOFT      = 3'd5
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_rst_seq_sync2.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 0.
module pll_rst_seq_sync2 (
  input  logic clk,
  input  logic resetb,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL start-up / reset sequencer: pulses PLL reset, qualifies lock, then releases
// peripheral and CPU resets in order; handles lock loss, timeouts and soft resets.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES  = 4,
  parameter int LOCK_TIMEOUT    = 4096,
  parameter int LOCK_CYCLES     = 1024,
  parameter int CPU_DELAY       = 16,
  parameter int SOFT_RST_CYCLES = 8
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              pll_locked,
  input  logic              soft_rst_req,
  output logic              pll_resetb,
  output logic              periph_rstn,
  output logic              cpu_rstn,
  output logic              ready,
  output logic [STATE_W-1:0] state,
  output logic [LOSS_W-1:0]  lock_loss_cnt
);

  localparam int MAX_CYC = max2(max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                     max2(LOCK_CYCLES, CPU_DELAY)), SOFT_RST_CYCLES);
  localparam int CTR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Terminal counts: the counter starts at 0 on state entry, so the last cycle is N-1.
  localparam logic [CTR_W-1:0] RST_LAST  = CTR_W'(PLL_RST_CYCLES - 1);
  localparam logic [CTR_W-1:0] TO_LAST   = CTR_W'(LOCK_TIMEOUT - 1);
  localparam logic [CTR_W-1:0] LOCK_LAST = CTR_W'(LOCK_CYCLES - 1);
  localparam logic [CTR_W-1:0] CPU_LAST  = CTR_W'(CPU_DELAY - 1);
  localparam logic [CTR_W-1:0] SOFT_LAST = CTR_W'(SOFT_RST_CYCLES - 1);

  logic             lock_s;
  state_t           state_q;
  state_t           nxt;
  logic             loss;
  logic [CTR_W-1:0] count;

  pll_rst_seq_sync2 u_lock_sync (
    .clk    (clk),
    .resetb (resetb),
    .d      (pll_locked),
    .q      (lock_s)
  );

  always_comb begin
    nxt  = state_q;
    loss = 1'b0;
    case (state_q)
      ST_PLL_RST: begin
        if (count == RST_LAST) nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) nxt = ST_STABLE;
        else if (count == TO_LAST) nxt = ST_PLL_RST;
      end
      ST_STABLE: begin
        if (!lock_s) nxt = ST_WAIT_LOCK;
        else if (count == LOCK_LAST) nxt = ST_PERIPH;
      end
      ST_PERIPH, ST_RUN, ST_SOFT: begin
        // Lock loss outranks a soft request seen in the same cycle.
        if (!lock_s) begin
          nxt  = ST_WAIT_LOCK;
          loss = 1'b1;
        end else if (soft_rst_req && (state_q != ST_SOFT)) begin
          nxt = ST_SOFT;
        end else if ((state_q == ST_PERIPH) && (count == CPU_LAST)) begin
          nxt = ST_RUN;
        end else if ((state_q == ST_SOFT) && (count == SOFT_LAST)) begin
          nxt = ST_STABLE;
        end
      end
      default: nxt = ST_PLL_RST;
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q       <= ST_PLL_RST;
      count         <= '0;
      pll_resetb    <= 1'b0;
      periph_rstn   <= 1'b0;
      cpu_rstn      <= 1'b0;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state_q     <= nxt;
      count       <= (nxt != state_q) ? '0 : count + 1'b1;
      pll_resetb  <= (nxt != ST_PLL_RST);
      periph_rstn <= (nxt == ST_PERIPH) || (nxt == ST_RUN);
      cpu_rstn    <= (nxt == ST_RUN);
      ready       <= (nxt == ST_RUN);
      if (loss && (lock_loss_cnt != {LOSS_W{1'b1}}))
        lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end

  assign state = state_q;

endmodule
